// File: rtl/reg16_arb_pkg.sv
// Shared types and constants for the reg16 arbiter slice.
// Optional write-first read forwarding: REG16_ARB_FWD_EN.
package reg16_arb_pkg;

  localparam int DATA_W   = 16;
  localparam int MAX_NREQ = 8;
  localparam int OWNER_W  = 3;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_e;

  function automatic logic [OWNER_W-1:0] rr_next(
    input logic [OWNER_W-1:0] idx,
    input int                 n
  );
    return (int'(idx) == n - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/reg16_en.sv
// One 16-bit storage register with load enable and async clear.
module reg16_en
  import reg16_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/reg16_arbiter.sv
// Round-robin, lockable write arbiter in front of a 16-bit register bank.
// Define REG16_ARB_FWD_EN for write-first read forwarding.
module reg16_arbiter
  import reg16_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int NREG = 4,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_lock,
  input  logic [NREQ*AW-1:0]     req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic [AW-1:0]          rd_addr,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   locked,
  output logic [OWNER_W-1:0]     owner
);

  state_e               state_q, state_d;
  logic [OWNER_W-1:0]   ptr_q, ptr_d;
  logic [OWNER_W-1:0]   owner_q, owner_d;
  logic [OWNER_W-1:0]   gnt_idx;
  logic                 gnt_vld;
  logic                 gnt_lock;
  logic [NREQ-1:0]      ready;
  logic [AW-1:0]        waddr;
  logic [DATA_W-1:0]    wdata;
  logic [DATA_W-1:0]    bank_q [NREG];
  logic [DATA_W-1:0]    rd_q, rd_d;

  // Grant select: owner only while locked, else first valid from ptr.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (state_q == ST_LOCKED) begin
      for (int i = 0; i < NREQ; i++) begin
        if (OWNER_W'(i) == owner_q && req_valid[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = owner_q;
        end
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!gnt_vld && req_valid[i] &&
              ((int'(ptr_q) + k) % NREQ) == i) begin
            gnt_vld = 1'b1;
            gnt_idx = OWNER_W'(i);
          end
        end
      end
    end
  end

  always_comb begin
    ready = '0;
    waddr = '0;
    wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      ready[i] = gnt_vld && (gnt_idx == OWNER_W'(i));
      if (ready[i]) begin
        waddr = req_addr[i*AW +: AW];
        wdata = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign gnt_lock = |(ready & req_lock);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          owner_d = gnt_idx;
          ptr_d   = rr_next(gnt_idx, NREQ);
          if (gnt_lock) state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (gnt_vld && !gnt_lock) begin
          state_d = ST_IDLE;
          ptr_d   = rr_next(owner_q, NREQ);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  for (genvar k = 0; k < NREG; k++) begin : g_bank
    reg16_en u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (gnt_vld && (waddr == AW'(k))),
      .d_i   (wdata),
      .q_o   (bank_q[k])
    );
  end

  always_comb begin
    rd_d = bank_q[rd_addr];
`ifdef REG16_ARB_FWD_EN
    if (gnt_vld && (waddr == rd_addr)) rd_d = wdata;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign req_ready = ready;
  assign rd_data   = rd_q;
  assign locked    = (state_q == ST_LOCKED);
  assign owner     = owner_q;

endmodule

// File: tb/tb_reg16_arbiter.sv
// Randomized and directed bench for reg16_arbiter against a
// transaction-level model of the scheduler and register bank.
module tb_reg16_arbiter;

  localparam int NREQ = 4;
  localparam int NREG = 4;
  localparam int AW   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_lock;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*16-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [AW-1:0]     rd_addr;
  logic [15:0]       rd_data;
  logic              locked;
  logic [2:0]        owner;

  reg16_arbiter #(.NREQ(NREQ), .NREG(NREG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .locked    (locked),
    .owner     (owner)
  );

  always #5 clk = ~clk;

`ifdef REG16_ARB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // reference state
  int          m_ptr;
  int          m_owner;
  bit          m_lock;
  logic [15:0] m_mem [NREG];
  logic [15:0] m_rd;

  logic [AW-1:0] a [NREQ];
  logic [15:0]   d [NREQ];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_owner = 0;
    m_lock  = 1'b0;
    m_rd    = '0;
    for (int k = 0; k < NREG; k++) m_mem[k] = '0;
  endtask

  task automatic cyc(input logic [NREQ-1:0] v, input logic [NREQ-1:0] l,
                     input logic [AW-1:0] ra, output int g);
    logic [NREQ-1:0] exp_rdy;
    @(negedge clk);
    req_valid = v;
    req_lock  = l;
    rd_addr   = ra;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = a[i];
      req_data[i*16 +: 16] = d[i];
    end
    #1;
    g = -1;
    if (m_lock) begin
      if (v[2'(m_owner)]) g = m_owner;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int i = (m_ptr + k) % NREQ;
        if (g < 0 && v[2'(i)]) g = i;
      end
    end
    exp_rdy = (g < 0) ? '0 : NREQ'(1 << g);
    chk("ready", 64'(req_ready), 64'(exp_rdy));
    m_rd = m_mem[ra];
    if (g >= 0) begin
      if (FWD && a[g] == ra) m_rd = d[g];
      m_mem[a[g]] = d[g];
      if (!m_lock) begin
        m_owner = g;
        m_ptr   = (g + 1) % NREQ;
        if (l[2'(g)]) m_lock = 1'b1;
      end else if (!l[2'(g)]) begin
        m_lock = 1'b0;
        m_ptr  = (g + 1) % NREQ;
      end
    end
    @(posedge clk);
    #1;
    chk("rd_data", 64'(rd_data), 64'(m_rd));
    chk("locked", 64'(locked), 64'(m_lock));
    chk("owner", 64'(owner), 64'(m_owner));
  endtask

  int g;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_data  = '0;
    rd_addr   = '0;
    for (int i = 0; i < NREQ; i++) begin
      a[i] = '0;
      d[i] = '0;
    end
    model_reset();
    #2;
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_rd", 64'(rd_data), 64'h0);
    chk("rst_locked", 64'(locked), 64'h0);
    chk("rst_owner", 64'(owner), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // all four requesters, one grant per cycle in order
    for (int i = 0; i < NREQ; i++) begin
      a[i] = AW'(i);
      d[i] = 16'(16'h1111 * (i + 1));
    end
    for (int i = 0; i < NREQ; i++) begin
      cyc(NREQ'(4'hF << i), '0, '0, g);
      chk("seq_gnt", 64'(g), 64'(i));
    end
    for (int k = 0; k < NREG; k++) begin
      cyc('0, '0, AW'(k), g);
      chk("seq_rd", 64'(rd_data), 64'(16'h1111 * (k + 1)));
    end

    // lone requester re-granted back to back
    a[2] = 2'd1;
    d[2] = 16'hA5A5; cyc(4'b0100, '0, '0, g); chk("solo0", 64'(g), 64'd2);
    d[2] = 16'h5A5A; cyc(4'b0100, '0, '0, g); chk("solo1", 64'(g), 64'd2);
    d[2] = 16'hFFFF; cyc(4'b0100, '0, '0, g); chk("solo2", 64'(g), 64'd2);
    cyc('0, '0, 2'd1, g);
    chk("solo_rd", 64'(rd_data), 64'hFFFF);
    cyc(4'b1111, '0, '0, g);
    chk("ptr3", 64'(g), 64'd3);
    cyc(4'b0001, '0, '0, g);

    // locked burst by requester 1 with 0 and 3 contending
    a[1] = 2'd3;
    cyc(4'b1011, 4'b0010, '0, g);
    chk("lk_b0", 64'(g), 64'd1); chk("lk_on0", 64'(locked), 64'd1);
    cyc(4'b1011, 4'b0010, '0, g);
    chk("lk_b1", 64'(g), 64'd1); chk("lk_on1", 64'(locked), 64'd1);
    cyc(4'b1001, 4'b0010, '0, g);
    chk("lk_hold", 64'(locked), 64'd1);
    cyc(4'b1011, 4'b0000, '0, g);
    chk("lk_b2", 64'(g), 64'd1); chk("lk_off", 64'(locked), 64'd0);
    cyc(4'b1011, 4'b0000, '0, g);
    chk("lk_next", 64'(g), 64'd3);

    // same-cycle write and read of one address
    a[0] = 2'd2; d[0] = 16'h0001;
    cyc(4'b0001, '0, '0, g);
    d[0] = 16'hBEEF;
    cyc(4'b0001, '0, 2'd2, g);
    chk("rw_same", 64'(rd_data), FWD ? 64'hBEEF : 64'h0001);

    // reset in the middle of a locked burst
    cyc(4'b0001, 4'b0001, '0, g);
    cyc(4'b0001, 4'b0001, 2'd2, g);
    @(negedge clk);
    #2;
    req_valid = '0;
    rst_n     = 1'b0;
    #1;
    chk("mid_rst_rd", 64'(rd_data), 64'h0);
    chk("mid_rst_lk", 64'(locked), 64'h0);
    chk("mid_rst_own", 64'(owner), 64'h0);
    chk("mid_rst_rdy", 64'(req_ready), 64'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NREG; k++) begin
      cyc('0, '0, AW'(k), g);
      chk("rst_reg", 64'(rd_data), 64'h0);
    end
    cyc(4'b1111, '0, '0, g);
    chk("rst_first", 64'(g), 64'd0);

    // quiet interval
    for (int c = 0; c < 10; c++) begin
      cyc('0, '0, AW'(c % NREG), g);
      chk("idle_rdy", 64'(req_ready), 64'h0);
    end

    // random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        a[i] = AW'($urandom);
        d[i] = 16'($urandom);
      end
      cyc(NREQ'($urandom),
          ($urandom_range(0, 2) == 0) ? NREQ'($urandom) : '0,
          AW'($urandom), g);
    end
    for (int k = 0; k < NREG; k++) begin
      cyc('0, '0, AW'(k), g);
      chk("final_reg", 64'(rd_data), 64'(m_mem[k]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reg16_arbiter.md
# reg16_arbiter

Shares a small bank of 16-bit registers between several independent writers and provides one read port. Each clock cycle, a round-robin scheduler grants at most one write. A requester may lock the bank for a multi-beat burst. The block sits between requesting datapath units and the 16-bit storage registers, and sequences every load into them.

## Interface
Parameters:
- NREQ, 4, number of write requesters (2..8)
- NREG, 4, number of 16-bit registers in the bank (power of two, 2..16)
- AW, $clog2(NREG), register address width (derived)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NREQ  per-requester write request
- req_lock  input  NREQ  per-requester lock request, sampled with req_valid
- req_addr  input  NREQ*AW  packed target addresses; requester i is at [i*AW +: AW]
- req_data  input  NREQ*16  packed write data; requester i is at [i*16 +: 16]
- req_ready  output  NREQ  one-hot grant; a write happens on cycles where req_valid[i] && req_ready[i]
- rd_addr  input  AW  read address
- rd_data  output  16  registered read data
- locked  output  1  bank is held by a requester
- owner  output  3  index of the last granted or locking requester

## Operation
- Storage: NREG registers of 16 bits. Register k loads req_data of the granted requester when a handshake targets address k. Otherwise it holds its value.
- Round-robin arbitration: ptr (3 bits) names the highest-priority requester. Search starts at ptr and proceeds ptr+1 … modulo NREQ. The first set req_valid bit wins. After a handshake by requester g, ptr becomes (g+1) mod NREQ.
- req_ready is combinational from req_valid, ptr and state, and is always one-hot or zero. It is zero when no requests are valid.
- FSM states:
  - IDLE: normal round-robin.
  - LOCKED: only owner may be granted, and it is granted whenever its req_valid is high. All other requesters see ready=0.
- Transitions:
  - IDLE→LOCKED on a handshake by g with req_lock[g]=1; owner←g.
  - LOCKED→IDLE on an owner handshake with req_lock[owner]=0. That beat is still written.
  - The owner dropping req_valid while locked does not release the lock.
- ptr does not advance while in LOCKED. On exit from LOCKED, ptr becomes (owner+1) mod NREQ.
- Addresses wrap: req_addr is AW bits, so every value is in range.
- Reset (asynchronous, any time, including mid-burst):
  - all registers become 0, ptr becomes 0, state becomes IDLE, owner becomes 0, rd_data becomes 0.
  - locked=0, and req_ready is all zero until req_valid is seen after reset deassertion.

## Timing
- Write latency: data is visible in register k at the clock edge of the handshake.
- Read latency: one cycle. rd_data(t+1) = reg[rd_addr(t)] as held after edge t.
- Without forwarding, a read and a write to the same address in one cycle return the old value.
- Throughput: one write per cycle with no bubbles. A requester holding valid high may be re-granted on consecutive cycles only if no other requester is valid, or while it holds the lock.
- locked and owner are registered outputs that change on the edge after the handshake that causes the change.

## Configuration
- REG16_ARB_FWD_EN defined:
  - when a handshake in cycle t targets rd_addr(t), rd_data(t+1) returns that cycle's write data (write-first).
  - The combinational path from req_data to the rd_data register is added.
- Undefined: read-first behaviour as stated under Timing. Forwarding logic is absent.

## Structure
- Shared package reg16_arb_pkg holds:
  - the constants DATA_W=16, MAX_NREQ=8, OWNER_W=3
  - the FSM state enum (ST_IDLE, ST_LOCKED)
- Sub-module reg16_en: a single 16-bit register with load enable and asynchronous active-low clear. The bank instantiates it NREG times.
- The arbiter, FSM and read mux live in reg16_arbiter.

## Test plan
- Reset, then all four requesters valid to addresses 0..3 with data 0x1111, 0x2222, 0x3333, 0x4444 → grants 0,1,2,3 on consecutive cycles; reading addresses 0..3 then returns those values.
- Requester 2 alone, valid for 3 cycles to address 1 with data 0xA5A5, 0x5A5A, 0xFFFF → granted every cycle; address 1 ends at 0xFFFF; ptr=3.
- Requester 1 locks (lock=1) and writes 3 beats with requesters 0 and 3 valid throughout, last beat lock=0 → only requester 1 is granted for 3 cycles, locked=1 during the burst, then requester 3 is granted next (ptr=2 searches 2,3).
- Same-cycle write of 0xBEEF to address 2 and read of address 2 when it holds 0x0001 → rd_data=0x0001 without REG16_ARB_FWD_EN, 0xBEEF with it.
- rst_n pulsed low mid-lock burst → rd_data, locked, owner and all registers read 0 immediately; after release, requester 0 wins first when all are valid.
- No requests for 10 cycles → req_ready=0 every cycle and register contents unchanged.
